// File: rtl/iob2axi_sched.sv
// Round-robin scheduler granting a single iob2axi engine to one of two native clients.
// The granted client's native port is routed to the engine until its burst has retired.
module iob2axi_sched #(
   parameter int unsigned ADDR_W = 24,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned LEN_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              req,
   input  logic [1:0]              dir,
   input  logic [2*LEN_W-1:0]      len,
   output logic [1:0]              gnt,
   output logic [1:0]              done,
   output logic [1:0]              err,
   input  logic [1:0]              valid,
   input  logic [2*ADDR_W-1:0]     addr,
   input  logic [2*DATA_W-1:0]     wdata,
   input  logic [2*DATA_W/8-1:0]   wstrb,
   output logic [DATA_W-1:0]       rdata,
   output logic [1:0]              ready,
   output logic                    m_run,
   output logic                    m_direction,
   output logic [LEN_W-1:0]        m_length,
   input  logic                    m_ctrl_ready,
   input  logic                    m_error,
   output logic                    m_valid,
   output logic [ADDR_W-1:0]       m_addr,
   output logic [DATA_W-1:0]       m_wdata,
   output logic [DATA_W/8-1:0]     m_wstrb,
   input  logic [DATA_W-1:0]       m_rdata,
   input  logic                    m_ready
);

   typedef enum logic [1:0] {IDLE, RUN, XFER, DRAIN} state_t;

   state_t           state, state_nxt;
   logic             ptr;        // client favoured when both request
   logic             cur;
   logic [LEN_W-1:0] beat_cnt;
   logic [1:0]       err_q;
   logic             grant, sel, active, beat, last_beat, finish;

   assign cur       = gnt[1];
   assign active    = (state == RUN) || (state == XFER);
   assign beat      = m_valid & m_ready;
   assign last_beat = beat && (beat_cnt == m_length);
   assign grant     = (state == IDLE) && m_ctrl_ready && (req != 2'b00);
   assign sel       = (req == 2'b11) ? ptr : req[1];
   assign finish    = (state == DRAIN) && m_ctrl_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         gnt         <= '0;
         ptr         <= 1'b0;
         err_q       <= '0;
         beat_cnt    <= '0;
         m_direction <= 1'b0;
         m_length    <= '0;
      end else begin
         state <= state_nxt;
         if (grant) begin
            gnt         <= sel ? 2'b10 : 2'b01;
            m_direction <= dir[sel];
            m_length    <= sel ? len[2*LEN_W-1:LEN_W] : len[LEN_W-1:0];
            beat_cnt    <= '0;
            err_q[sel]  <= 1'b0;
         end
         if (active && beat)
            beat_cnt <= beat_cnt + LEN_W'(1);
         if (finish) begin
            gnt        <= '0;
            err_q[cur] <= m_error;
            ptr        <= ~cur;
         end
      end
   end

   // A single-beat burst can complete in RUN; skip XFER so no extra beat is admitted.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant) state_nxt = RUN;
         RUN:     state_nxt = last_beat ? DRAIN : XFER;
         XFER:    if (last_beat) state_nxt = DRAIN;
         DRAIN:   if (m_ctrl_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      m_run   = (state == RUN);
      m_valid = active & (cur ? valid[1] : valid[0]);
      m_addr  = cur ? addr[2*ADDR_W-1:ADDR_W]       : addr[ADDR_W-1:0];
      m_wdata = cur ? wdata[2*DATA_W-1:DATA_W]      : wdata[DATA_W-1:0];
      m_wstrb = cur ? wstrb[2*DATA_W/8-1:DATA_W/8]  : wstrb[DATA_W/8-1:0];
      ready   = gnt & {2{m_ready & active}};
      rdata   = m_rdata;
      done    = finish ? gnt : 2'b00;
      // The captured error is visible alongside its done pulse, then held.
      err     = err_q | (done & {2{m_error}});
   end

endmodule

// File: tb/tb_iob2axi_sched.sv
// Bench for iob2axi_sched: behavioural engine, per-client drivers, reference memory
// and round-robin model, with directed and randomized transfers.
module tb_iob2axi_sched;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 8;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [1:0]            req, dir, gnt, done, err, valid, ready;
   logic [2*LEN_W-1:0]    len;
   logic [2*ADDR_W-1:0]   addr;
   logic [2*DATA_W-1:0]   wdata;
   logic [2*DATA_W/8-1:0] wstrb;
   logic [DATA_W-1:0]     rdata;
   logic                  m_run, m_direction, m_error, m_valid;
   logic                  m_ctrl_ready = 1'b1;
   logic                  m_ready = 1'b0;
   logic [LEN_W-1:0]      m_length;
   logic [ADDR_W-1:0]     m_addr;
   logic [DATA_W-1:0]     m_wdata;
   logic [DATA_W-1:0]     m_rdata = '0;
   logic [DATA_W/8-1:0]   m_wstrb;

   logic [1:0]            req_c, dir_c, valid_c;
   logic [LEN_W-1:0]      len_c   [2];
   logic [ADDR_W-1:0]     addr_c  [2];
   logic [DATA_W-1:0]     wdata_c [2];
   logic                  err_inject;

   assign req   = req_c;
   assign dir   = dir_c;
   assign valid = valid_c;
   assign len   = {len_c[1], len_c[0]};
   assign addr  = {addr_c[1], addr_c[0]};
   assign wdata = {wdata_c[1], wdata_c[0]};
   assign wstrb = '1;
   assign m_error = err_inject;

   iob2axi_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .req(req), .dir(dir), .len(len), .gnt(gnt), .done(done), .err(err),
      .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready),
      .m_run(m_run), .m_direction(m_direction), .m_length(m_length), .m_ctrl_ready(m_ctrl_ready),
      .m_error(m_error), .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_rdata(m_rdata), .m_ready(m_ready)
   );

   always #5 clk = ~clk;

   int checks = 0, failures = 0;
   int last_served = 1;                 // round-robin model: favour client 0 after reset
   int exp_done = 0, done_cnt = 0, stray_ready = 0, early_done = 0, long_run = 0, eng_over = 0;
   int grant_q[$];
   logic [DATA_W-1:0] ref_mem [int];

   // Behavioural engine: memory slave that goes busy on run and retires after len+1 beats.
   logic [DATA_W-1:0] eng_mem [int];
   bit                eng_busy = 0, s_hs = 0, s_run = 0, s_dir = 0, prev_run = 0;
   int                eng_beats = 0, eng_need = 0, eng_tail = 0;
   logic [LEN_W-1:0]  s_len;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wdata;

   always @(negedge clk) begin
      s_hs = m_valid & m_ready;  s_run = m_run;  s_dir = m_direction;
      s_len = m_length;  s_addr = m_addr;  s_wdata = m_wdata;
      done_cnt += int'(done[0]) + int'(done[1]);
      if ((ready & ~gnt) != 2'b00) stray_ready++;
      if (done != 2'b00 && !m_ctrl_ready) early_done++;
      if (m_run && prev_run) long_run++;
      prev_run = m_run;
   end

   always @(posedge clk) begin
      if (rst) begin
         eng_busy = 0; eng_beats = 0; eng_need = 0;
      end else begin
         if (s_run) begin
            eng_busy = 1; eng_beats = 0; eng_need = int'(s_len) + 1;
            eng_tail = int'($urandom_range(0, 3));
         end
         if (s_hs) begin
            if (eng_beats >= eng_need) eng_over++;
            eng_beats++;
            if (s_dir) eng_mem[int'(s_addr)] = s_wdata;
         end
         if (eng_busy && eng_beats >= eng_need) begin
            if (eng_tail == 0) eng_busy = 0;
            else eng_tail--;
         end
      end
      #1;
      m_ready = ($urandom_range(0, 3) != 0);
      m_ctrl_ready = !eng_busy;
      #1;
      m_rdata = eng_mem.exists(int'(m_addr)) ? eng_mem[int'(m_addr)] : '0;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] ref_rd(input int a);
      return ref_mem.exists(a) ? ref_mem[a] : '0;
   endfunction

   // One client transfer; abort_at > 0 returns right after that many beats.
   task automatic xfer(input int n, input bit d, input int l, input int base, input int d0,
                       input int abort_at);
      int  i, t;
      bit  got;
      logic exp_err;
      req_c[n] = 1'b1; dir_c[n] = d; len_c[n] = LEN_W'(l);
      got = 0; t = 0;
      while (!got && t < 400) begin
         @(negedge clk);
         if (gnt[n]) got = 1; else t++;
      end
      req_c[n] = 1'b0;
      chk("gnt_seen", 64'(got), 64'd1);
      if (!got) return;
      grant_q.push_back(n);
      chk("gnt_onehot", 64'(gnt), (n == 0) ? 64'd1 : 64'd2);
      chk("run_pulse", 64'(m_run), 64'd1);
      chk("m_length", 64'(m_length), 64'(l));
      chk("m_direction", 64'(m_direction), 64'(d));
      chk("err_clr_at_gnt", 64'(err[n]), 64'd0);
      i = 0; t = 0;
      while (i <= l && t < 4000) begin
         @(posedge clk); #1;
         valid_c[n]   = ($urandom_range(0, 3) != 0);
         addr_c[n]    = ADDR_W'(base + i);
         wdata_c[n]   = DATA_W'(d0 + i);
         @(negedge clk);
         if (valid_c[n] && ready[n]) begin
            if (d) ref_mem[base + i] = DATA_W'(d0 + i);
            else   chk("rdata", 64'(rdata), 64'(ref_rd(base + i)));
            i++;
            if (i == abort_at) begin
               @(posedge clk); #1 valid_c[n] = 1'b0;
               return;
            end
         end
         t++;
      end
      @(posedge clk); #1 valid_c[n] = 1'b0;
      chk("beats", 64'(i), 64'(l + 1));
      got = 0; t = 0;
      while (!got && t < 400) begin
         @(negedge clk);
         if (done[n]) got = 1; else t++;
      end
      chk("done_seen", 64'(got), 64'd1);
      if (!got) return;
      exp_done++;
      exp_err = err_inject;
      chk("done_ctrl_ready", 64'(m_ctrl_ready), 64'd1);
      chk("eng_beats", 64'(eng_beats), 64'(l + 1));
      chk("done_other", 64'(done[1-n]), 64'd0);
      chk("err_at_done", 64'(err[n]), 64'(exp_err));
      last_served = n;
      @(negedge clk);
      chk("done_single", 64'(done[n]), 64'd0);
      chk("gnt_released", 64'(gnt[n]), 64'd0);
      chk("err_held", 64'(err[n]), 64'(exp_err));
   endtask

   initial begin
      int mode, l0, l1, exp_first;
      bit d0r, d1r;
      rst = 1'b1; req_c = '0; dir_c = '0; valid_c = '0; err_inject = 1'b0;
      for (int n = 0; n < 2; n++) begin
         len_c[n] = '0; addr_c[n] = '0; wdata_c[n] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", 64'(gnt), 0);          chk("rst_done", 64'(done), 0);
      chk("rst_err", 64'(err), 0);          chk("rst_run", 64'(m_run), 0);
      chk("rst_dir", 64'(m_direction), 0);  chk("rst_len", 64'(m_length), 0);
      chk("rst_mvalid", 64'(m_valid), 0);   chk("rst_ready", 64'(ready), 0);
      @(posedge clk); #1 rst = 1'b0;

      xfer(0, 1'b1, 0, 'h100, 1, 0);
      chk("single_err", 64'(err), 0);
      xfer(1, 1'b1, 2, 12, 4, 0);
      xfer(1, 1'b0, 2, 12, 0, 0);

      xfer(0, 1'b1, 0, 'h200, 77, 0);
      for (int r = 0; r < 2; r++) begin
         exp_first = 1 - last_served;
         grant_q.delete();
         fork
            xfer(0, 1'b1, 1, 'h300 + 4*r, 10, 0);
            xfer(1, 1'b1, 1, 'h1300 + 4*r, 20, 0);
         join
         chk("cont_count", 64'(grant_q.size()), 64'd2);
         if (grant_q.size() == 2) begin
            chk("cont_first", 64'(grant_q[0]), 64'(exp_first));
            chk("cont_second", 64'(grant_q[1]), 64'(1 - exp_first));
         end
      end

      xfer(0, 1'b1, 255, 'h4000, 32, 0);
      xfer(0, 1'b0, 255, 'h4000, 0, 0);

      err_inject = 1'b1;
      xfer(0, 1'b1, 1, 'h500, 3, 0);
      err_inject = 1'b0;
      @(negedge clk);
      chk("err_capture", 64'(err), 64'd1);
      xfer(1, 1'b1, 0, 'h1500, 9, 0);
      chk("err0_held", 64'(err), 64'd1);
      xfer(0, 1'b0, 1, 'h500, 0, 0);
      chk("err0_cleared", 64'(err), 64'd0);

      for (int k = 0; k < 10; k++) begin
         mode = int'($urandom_range(0, 2));
         d0r = 1'($urandom_range(0, 1));  d1r = 1'($urandom_range(0, 1));
         l0 = int'($urandom_range(0, 7)); l1 = int'($urandom_range(0, 7));
         if (mode == 2) begin
            exp_first = 1 - last_served;
            grant_q.delete();
            fork
               xfer(0, d0r, l0, 'h2000 + 8*(k % 4), int'($urandom), 0);
               xfer(1, d1r, l1, 'h3000 + 8*(k % 4), int'($urandom), 0);
            join
            if (grant_q.size() > 0) chk("rand_first", 64'(grant_q[0]), 64'(exp_first));
         end else begin
            xfer(mode, d0r, l0, 'h2000 + 'h1000*mode + 8*(k % 4), int'($urandom), 0);
         end
      end

      xfer(0, 1'b1, 9, 'h600, 50, 3);
      rst = 1'b1;
      last_served = 1;
      @(negedge clk);
      chk("rst_mid_nodone", 64'(done), 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_gnt", 64'(gnt), 0);
      chk("rst_mid_mvalid", 64'(m_valid), 0);
      chk("rst_mid_done", 64'(done), 0);
      chk("rst_mid_run", 64'(m_run), 0);
      xfer(1, 1'b1, 2, 'h1600, 70, 0);
      xfer(1, 1'b0, 2, 'h1600, 0, 0);

      repeat (2) @(negedge clk);
      chk("done_total", 64'(done_cnt), 64'(exp_done));
      chk("stray_ready", 64'(stray_ready), 0);
      chk("done_while_busy", 64'(early_done), 0);
      chk("run_width", 64'(long_run), 0);
      chk("engine_overrun", 64'(eng_over), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
